// File: rtl/instruction_controller.sv
// Control FSM for the 16-bit RISC datapath: latches an instruction on s and
// sequences decode, operand fetch, compute and write-back as Moore outputs.
module instruction_controller #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s,
    input  logic [15:0]      instr,
    output logic             w,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic [1:0]       vsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic             loadc,
    output logic             loads,
    output logic [width-1:0] sximm8,
    output logic [width-1:0] sximm5
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_WAIT      = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_GET_A     = 3'd2;
    localparam logic [STATE_W-1:0] ST_GET_B     = 3'd3;
    localparam logic [STATE_W-1:0] ST_COMPUTE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_WRITE_REG = 3'd5;
    localparam logic [STATE_W-1:0] ST_WRITE_IMM = 3'd6;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [INSTR_W-1:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);
    assign is_mvn     = is_alu && (op == OP_MVN);

    // Immediates track IR in every state
    assign sximm8 = {{(width-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(width-5){ir[4]}}, ir[4:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // IR only updates on an accepted start, so it is stable through the instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if ((state == ST_WAIT) && s) begin
            ir <= instr;
        end
    end

    always_comb begin
        state_next = state;
        w          = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        vsel       = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        loadc      = 1'b0;
        loads      = 1'b0;

        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_mov_imm) begin
                    state_next = ST_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_next = ST_GET_B;
                end else if (is_alu) begin
                    state_next = ST_GET_A;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = ST_GET_B;
            end
            ST_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                shift = sh;
                // MOV reg passes B through an ADD with A forced to zero
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                    loadc = 1'b1;
                end else begin
                    ALUop = op;
                    loadc = !is_cmp;
                    loads = is_cmp;
                end
                state_next = is_cmp ? ST_WAIT : ST_WRITE_REG;
            end
            ST_WRITE_REG: begin
                writenum   = rd;
                write      = 1'b1;
                vsel       = 2'b00;
                state_next = ST_WAIT;
            end
            ST_WRITE_IMM: begin
                writenum   = rn;
                write      = 1'b1;
                vsel       = 2'b01;
                state_next = ST_WAIT;
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

endmodule

// File: doc/instruction_controller.md
# instruction_controller

Moore-style control FSM that issues the per-cycle control word for the 16-bit RISC datapath: register-file read/write selects, A/B pipeline register loads, and the computation-stage controls (asel, bsel, shift, ALUop, loadc, loads). It latches one instruction on a start handshake and sequences it through decode, operand fetch, compute and write-back. It then signals completion by returning to the wait state. It sits between the instruction source and the datapath, and drives the control inputs that the computation stage consumes.

## Interface
- width, 16, datapath word width; sign-extended immediate outputs are this wide.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- s  in  1  start; sampled only in WAIT.
- instr  in  16  instruction word; captured into the internal IR when s is accepted.
- w  out  1  high only in WAIT (idle/ready).
- readnum  out  3  register-file read index.
- writenum  out  3  register-file write index.
- write  out  1  register-file write enable.
- vsel  out  2  write-back mux select: 00 = C, 01 = sximm8, others unused.
- loada, loadb  out  1  A/B register load enables.
- asel  out  1  1 forces the ALU A operand to 0.
- bsel  out  1  1 selects sximm5 for the B operand; this block always drives 0.
- shift  out  2  shifter control, equal to IR[4:3] in COMPUTE.
- ALUop  out  2  ALU operation.
- loadc, loads  out  1  C register and status register load enables.
- sximm8  out  width  sign extension of IR[7:0].
- sximm5  out  width  sign extension of IR[4:0].

## Operation
- Instruction fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8.
  - 110/00: MOV Rd,Rm{,sh}.
  - 101/00: ADD.
  - 101/01: CMP.
  - 101/10: AND.
  - 101/11: MVN.
  - Anything else is unsupported and is treated as a no-op.
- States: WAIT, DECODE, GET_A, GET_B, COMPUTE, WRITE_REG, WRITE_IMM.
- Transitions:
  - WAIT: moves to DECODE when s=1, loading IR. Otherwise it stays in WAIT and IR holds.
  - DECODE to WRITE_IMM for MOV imm.
  - DECODE to GET_B for MOV reg and MVN.
  - DECODE to GET_A for ADD, CMP and AND.
  - DECODE to WAIT for unsupported instructions.
  - GET_A to GET_B.
  - GET_B to COMPUTE.
  - COMPUTE to WAIT for CMP, otherwise to WRITE_REG.
  - WRITE_REG to WAIT.
  - WRITE_IMM to WAIT.
- Outputs per state. Every output not listed is 0, and readnum/writenum are 0.
  - WAIT: w=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - COMPUTE:
    - shift=sh, bsel=0.
    - For ALU class: ALUop=op and asel=0. For CMP: loads=1, loadc=0. For ADD/AND/MVN: loadc=1.
    - For MOV reg: ALUop=00, asel=1, loadc=1.
  - WRITE_REG: writenum=Rd, write=1, vsel=00.
  - WRITE_IMM: writenum=Rn, write=1, vsel=01.
- sximm8 and sximm5 are combinational from IR and valid in every state.
- Bit (width-1) down to bit 8 (or bit 5) replicates the immediate's sign bit.

## Timing
- Reset (reset_n=0, any time, including mid-instruction):
  - State goes to WAIT immediately, without waiting for a clock.
  - IR clears to 0, w=1, all other control outputs are 0.
  - No write may occur after reset asserts.
- All control outputs are pure functions of state and IR (Moore), with no combinational path from s or instr.
- Number of non-WAIT cycles per instruction:
  - MOV imm: 2.
  - MOV reg: 4.
  - MVN: 4.
  - ADD: 5.
  - AND: 5.
  - CMP: 4.
  - Unsupported: 1.
- s and instr are ignored outside WAIT. IR is stable from acceptance until the next acceptance.
- s held high is allowed. The next instruction is accepted on the first edge spent in WAIT, which gives exactly one w=1 cycle between back-to-back instructions.
- Exactly one write pulse per writing instruction, one cycle wide. CMP and unsupported instructions produce no write pulse.

## Test plan
- Reset: assert reset_n=0 mid-ADD (in GET_B) and drop it between clock edges.
  - Required: w=1 and loadb=0 immediately, with no write afterwards.
  - After reset release with s=0: remains in WAIT.
- MOV imm: instr=0xD1FE, s pulse.
  - Required: 2 cycles with w=0. In WRITE_IMM: write=1, writenum=1, vsel=01, sximm8=0xFFFE.
- ADD: instr=0xA148 (ADD R2,R1,R0,LSL#1).
  - Required: GET_A has readnum=1, loada=1. GET_B has readnum=0, loadb=1.
  - COMPUTE has shift=01, ALUop=00, loadc=1. WRITE_REG has writenum=2, write=1.
  - Total 5 cycles with w=0.
- CMP: instr=0xA900.
  - Required: COMPUTE has ALUop=01, loads=1, loadc=0, then WAIT. write never asserts; 4 cycles with w=0.
- MOV reg: instr=0xC070.
  - Required: GET_B has readnum=0. COMPUTE has asel=1, ALUop=00, shift=10. WRITE_REG has writenum=3.
- Robustness cases:
  - Unsupported instr=0xE000 gives one DECODE cycle, then WAIT, with no loads or writes.
  - Changing instr mid-ADD does not alter readnum or writenum.
  - s held high gives one w=1 cycle between consecutive instructions.
